display_7seg_bcd: RTL and testbench
===================================

DISPLAY_7SEG_BCD -- requirements
Module: display_7seg_bcd

Interface
REQ-001 The module SHALL have parameter REFRESH_CNT, default 10000, the clock cycles each digit stays lit (1 ms at 10 MHz).
REQ-002 The module SHALL have port clk, input, 1, the single system clock (10 MHz).
REQ-003 The module SHALL have port rst_n_i, input, 1, the reset; it is asynchronous and active-low.
REQ-004 The module SHALL have port value_i, input, 8, the unsigned binary value to display (count from the contador).
REQ-005 The module SHALL have port seg_o, output, 7, the segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-006 The module SHALL have port an_o, output, 4, the digit anodes, active-low; bit0 = units, bit1 = tens, bit2 = hundreds, bit3 unused.
REQ-007 The module SHALL have port busy_o, output, 1, high while a binary-to-BCD conversion is in progress.

Function
REQ-008 The conversion FSM SHALL have the states IDLE, SHIFT and LOAD.
REQ-009 In IDLE, if value_i != last_value, the FSM SHALL capture value_i into the shift register, clear the 12-bit BCD accumulator and go to SHIFT; otherwise it SHALL stay in IDLE.
REQ-010 SHIFT SHALL last exactly 8 cycles; each cycle, every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1 (double dabble).
REQ-011 In LOAD (1 cycle), the FSM SHALL copy the BCD accumulator into the display register, set last_value to the captured value and return to IDLE.
REQ-012 Latency SHALL be fixed: the display register updates 10 clock edges after the IDLE edge that captured value_i.
REQ-013 busy_o SHALL be high during SHIFT and LOAD (9 cycles per conversion) and low in IDLE.
REQ-014 Changes of value_i during SHIFT or LOAD SHALL be ignored; the next IDLE cycle re-compares, so the final value is always displayed.
REQ-015 The display register SHALL only change in LOAD; intermediate accumulator values SHALL never reach seg_o.
REQ-016 The refresh counter SHALL count 0..REFRESH_CNT-1 and wrap; on wrap, the digit index SHALL advance 0->1->2->0 (never 3).
REQ-017 an_o SHALL be 4'b1110, 4'b1101 or 4'b1011 for digit index 0, 1 or 2 respectively; an_o[3] SHALL always be 1.
REQ-018 seg_o SHALL be decoded combinationally from the registered digit index and display register, with no latency beyond those registers.
REQ-019 The segment table for digits 0-9 SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 Leading-zero blanking: the hundreds digit SHALL show blank (1111111) when it is 0; the tens digit SHALL show blank when both hundreds and tens are 0; units SHALL always be shown.
REQ-021 Scanning SHALL continue unaffected during conversions.

Reset
REQ-022 While rst_n_i = 0, the module SHALL immediately (asynchronously) clear the FSM to IDLE and clear the shift register, BCD accumulator, display register, last_value, refresh counter and digit index to 0.
REQ-023 While rst_n_i = 0, outputs SHALL be an_o = 4'b1110, seg_o = 7'b1000000 ("0" on units) and busy_o = 0.
REQ-024 A reset mid-conversion SHALL abort the conversion with no partial update.
REQ-025 After reset release, a nonzero value_i SHALL start a conversion on the first clock edge.

Verification (bench uses REFRESH_CNT = 4)
REQ-026 Reset with value_i = 0 -> an_o = 1110, seg_o = 1000000; on digits 1 and 2, seg_o = 1111111; an_o steps every 4 cycles through 1110 -> 1101 -> 1011 -> 1110.
REQ-027 value_i 0 -> 255 -> busy_o high for exactly 9 cycles; 10 edges after capture the displayed digits are 2/5/5 (0100100, 0010010, 0010010).
REQ-028 value_i = 7 -> hundreds and tens blank, units 1111000; value_i = 100 -> digits 1/0/0 with tens shown as 1000000 (not blanked).
REQ-029 value_i 255, then 42 three cycles into SHIFT -> 255 is displayed first, then a second conversion shows 0/4/2 with hundreds blank; at no point is another value displayed.
REQ-030 rst_n_i asserted mid-SHIFT of value 200 -> busy_o = 0 and display shows "0" immediately; after release, 200 is converted and displayed.

Source files
------------

// File: rtl/display_7seg_bcd.sv
// Three-digit multiplexed 7-segment driver for an 8-bit unsigned value.
// A double-dabble FSM converts each new value to BCD, and a refresh counter scans the digits.
module display_7seg_bcd #(
    parameter int REFRESH_CNT = 10000
) (
    input  logic       clk,
    input  logic       rst_n_i,
    input  logic [7:0] value_i,
    output logic [6:0] seg_o,
    output logic [3:0] an_o,
    output logic       busy_o
);

    localparam int RW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_CNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t          r_state;
    logic [7:0]      r_shift;
    logic [7:0]      r_cap;
    logic [7:0]      r_last;
    logic [11:0]     r_bcd;
    logic [11:0]     r_disp;
    logic [2:0]      r_bitcnt;
    logic            r_busy;
    logic [RW-1:0]   r_refresh;
    logic [1:0]      r_digit;
    logic [11:0]     w_adj;
    logic [3:0]      w_nibble;
    logic            w_blank;

    function automatic logic [3:0] nib_adjust(input logic [3:0] n);
        if (n >= 4'd5) begin
            return n + 4'd3;
        end else begin
            return n;
        end
    endfunction

    function automatic logic [11:0] dd_adjust(input logic [11:0] bcd);
        return {nib_adjust(bcd[11:8]), nib_adjust(bcd[7:4]), nib_adjust(bcd[3:0])};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Add-3 correction applied to the accumulator before each shift.
    always_comb begin
        w_adj = dd_adjust(r_bcd);
    end

    // Conversion FSM: capture edge + 8 shift edges + load edge = 10 edges to display update.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= IDLE;
            r_shift  <= 8'd0;
            r_cap    <= 8'd0;
            r_last   <= 8'd0;
            r_bcd    <= 12'd0;
            r_disp   <= 12'd0;
            r_bitcnt <= 3'd0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (value_i != r_last) begin
                        r_shift  <= value_i;
                        r_cap    <= value_i;
                        r_bcd    <= 12'd0;
                        r_bitcnt <= 3'd0;
                        r_busy   <= 1'b1;
                        r_state  <= SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_bcd    <= {w_adj[10:0], r_shift[7]};
                    r_shift  <= {r_shift[6:0], 1'b0};
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        r_state <= LOAD;
                    end else begin
                        r_state <= SHIFT;
                    end
                end
                LOAD: begin
                    r_disp  <= r_bcd;
                    r_last  <= r_cap;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Refresh counter and digit index; the index cycles units -> tens -> hundreds.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_refresh <= '0;
            r_digit   <= 2'd0;
        end else if (r_refresh == REF_MAX) begin
            r_refresh <= '0;
            case (r_digit)
                2'd0:    r_digit <= 2'd1;
                2'd1:    r_digit <= 2'd2;
                default: r_digit <= 2'd0;
            endcase
        end else begin
            r_refresh <= r_refresh + {{(RW-1){1'b0}}, 1'b1};
        end
    end

    // Anode select, digit pick and leading-zero blanking from the registered state.
    always_comb begin
        an_o     = 4'b1111;
        w_nibble = 4'd0;
        w_blank  = 1'b0;
        case (r_digit)
            2'd0: begin
                an_o     = 4'b1110;
                w_nibble = r_disp[3:0];
                w_blank  = 1'b0;
            end
            2'd1: begin
                an_o     = 4'b1101;
                w_nibble = r_disp[7:4];
                w_blank  = (r_disp[11:8] == 4'd0) && (r_disp[7:4] == 4'd0);
            end
            2'd2: begin
                an_o     = 4'b1011;
                w_nibble = r_disp[11:8];
                w_blank  = (r_disp[11:8] == 4'd0);
            end
            default: begin
                an_o     = 4'b1111;
                w_nibble = 4'd0;
                w_blank  = 1'b1;
            end
        endcase
        if (w_blank) begin
            seg_o = 7'b1111111;
        end else begin
            seg_o = seg_decode(w_nibble);
        end
    end

    assign busy_o = r_busy;

endmodule

// File: tb/tb_display_7seg_bcd.sv
// Scoreboard bench: the driver queues each value it expects to see displayed; a negedge
// monitor checks anodes and segments every cycle against a decimal reference model.
module tb_display_7seg_bcd;

    logic       clk;
    logic       rst_n_i;
    logic [7:0] value_i;
    logic [6:0] seg_o;
    logic [3:0] an_o;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int cur_disp = 0;
    int k_edges  = 0;
    int busy_run = 0;
    logic prev_busy = 1'b0;
    int prev_val = 0;

    display_7seg_bcd #(.REFRESH_CNT(4)) dut (
        .clk     (clk),
        .rst_n_i (rst_n_i),
        .value_i (value_i),
        .seg_o   (seg_o),
        .an_o    (an_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int dig);
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        if (dig == 0) return seg_of(u);
        if (dig == 1) return (h == 0 && t == 0) ? 7'b1111111 : seg_of(t);
        return (h == 0) ? 7'b1111111 : seg_of(h);
    endfunction

    function automatic logic [3:0] exp_an(input int dig);
        if (dig == 0) return 4'b1110;
        if (dig == 1) return 4'b1101;
        return 4'b1011;
    endfunction

    // Clock edges seen since reset release; the scan position follows from it directly.
    always @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) k_edges <= 0;
        else          k_edges <= k_edges + 1;
    end

    // Monitor: pop the next expected value when a conversion completes, check the scan every cycle.
    always @(negedge clk) begin
        int dig;
        if (!rst_n_i) begin
            cur_disp  = 0;
            busy_run  = 0;
            prev_busy = 1'b0;
            check("reset_busy", int'(busy_o), 0);
            check("reset_an", int'(an_o), int'(4'b1110));
            check("reset_seg", int'(seg_o), int'(7'b1000000));
        end else begin
            if (prev_busy && !busy_o) begin
                check("busy_len", busy_run, 9);
                if (exp_q.size() == 0) begin
                    check("unexpected_conversion", 1, 0);
                end else begin
                    cur_disp = exp_q.pop_front();
                end
            end
            if (busy_o) busy_run++;
            else        busy_run = 0;
            prev_busy = busy_o;
            dig = (k_edges / 4) % 3;
            check($sformatf("an_val%0d_dig%0d", cur_disp, dig), int'(an_o), int'(exp_an(dig)));
            check($sformatf("seg_val%0d_dig%0d", cur_disp, dig), int'(seg_o), int'(exp_seg(cur_disp, dig)));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy_o && n < 5) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy_rise", int'(busy_o), 1);
    endtask

    task automatic drive(input int v);
        if (v != prev_val) exp_q.push_back(v);
        value_i  = 8'(v);
        prev_val = v;
    endtask

    initial begin
        int v;
        rst_n_i = 1'b0;
        value_i = 8'd0;
        cycles(3);
        rst_n_i = 1'b1;

        // Idle scan with value 0: blanked tens/hundreds, no conversion.
        cycles(14);
        check("idle_busy", int'(busy_o), 0);

        // 255: capture on the first edge, then displayed as 2/5/5.
        drive(255);
        @(posedge clk);
        #1;
        check("capture_first_edge", int'(busy_o), 1);
        cycles(25);

        drive(7);
        cycles(25);
        drive(100);
        cycles(25);

        // Change during SHIFT: 255 shown first, then 42.
        drive(255);
        wait_busy();
        repeat (3) @(posedge clk);
        #2;
        drive(42);
        cycles(35);
        check("mid_change_drained", exp_q.size(), 0);

        // Reset mid-SHIFT of 200: immediate clear, then 200 converts after release.
        drive(200);
        wait_busy();
        repeat (3) @(posedge clk);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async_busy", int'(busy_o), 0);
        check("async_seg", int'(seg_o), int'(7'b1000000));
        check("async_an", int'(an_o), int'(4'b1110));
        cycles(3);
        rst_n_i = 1'b1;
        cycles(30);
        check("post_reset_drained", exp_q.size(), 0);

        for (int i = 0; i < 24; i++) begin
            v = $urandom_range(255, 0);
            drive(v);
            cycles(25);
        end
        drive(0);
        cycles(25);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
